// File: rtl/rst_set_pkg.sv
// rst_set_pkg: state encoding and default timing parameters shared by the reset/set generator.
package rst_set_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, IDLE = 2'd1, SETP = 2'd2, SOFTR = 2'd3} state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int RST_HOLD_DEF = 8;
  localparam int SET_HOLD_DEF = 4;
endpackage

// File: rtl/rst_set_gen_sync.sv
// rst_sync: async-assert / sync-deassert chain cleared by either reset source.
module rst_sync #(
  parameter int SYNC_STAGES = rst_set_pkg::SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_rst_n,
  output logic sync_n
);
  logic arst_n;
  logic [SYNC_STAGES-1:0] chain;
  assign arst_n = rst & ext_rst_n;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) chain <= '0;
    else chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  assign sync_n = chain[SYNC_STAGES-1];
endmodule

// File: rtl/rst_set_gen.sv
// rst_set_gen: generates a synchronised downstream reset plus soft reset and set pulses.
module rst_set_gen
  import rst_set_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF,
  parameter int SET_HOLD = SET_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_rst_n,
  input  logic       soft_rst_req,
  input  logic       soft_set_req,
  output logic       rst_o_n,
  output logic       set_o,
  output logic [1:0] state,
  output logic       ready
);
  localparam int HMAX = RST_HOLD > SET_HOLD ? RST_HOLD : SET_HOLD;
  localparam int CW = $clog2(HMAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(HMAX);
  logic arst_n, sync_n, rst_q, set_q, rst_d, set_d, rst_done, set_done;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  state_t st, st_d;
  assign arst_n = rst & ext_rst_n;
  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .ext_rst_n(ext_rst_n),
    .sync_n(sync_n)
  );
  assign cnt_inc = cnt == CMAX ? cnt : cnt + CW'(1);
  assign rst_done = cnt == CW'(RST_HOLD - 1);
  assign set_done = cnt == CW'(SET_HOLD - 1);
  // Soft reset always wins over a set request, and also aborts a set in progress.
  always_comb begin
    st_d = st;
    cnt_d = cnt_inc;
    rst_d = rst_q;
    set_d = set_q;
    unique case (st)
      HOLD: begin
        if (!sync_n) cnt_d = cnt;
        else if (rst_done) begin
          st_d = IDLE;
          cnt_d = '0;
          rst_d = 1'b1;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (soft_rst_req) begin
          st_d = SOFTR;
          rst_d = 1'b0;
        end else if (soft_set_req) begin
          st_d = SETP;
          set_d = 1'b1;
        end
      end
      SETP: begin
        if (soft_rst_req) begin
          st_d = SOFTR;
          cnt_d = '0;
          rst_d = 1'b0;
          set_d = 1'b0;
        end else if (set_done) begin
          st_d = IDLE;
          cnt_d = '0;
          set_d = 1'b0;
        end
      end
      SOFTR: begin
        if (rst_done) begin
          st_d = IDLE;
          cnt_d = '0;
          rst_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      st <= HOLD;
      cnt <= '0;
      rst_q <= 1'b0;
      set_q <= 1'b0;
    end else begin
      st <= st_d;
      cnt <= cnt_d;
      rst_q <= rst_d;
      set_q <= set_d;
    end
  assign rst_o_n = rst_q;
  assign set_o = set_q;
  assign state = st;
  assign ready = st == IDLE && rst_q;
endmodule

// File: tb/tb_rst_set_gen.sv
// tb_rst_set_gen: directed and random stimulus checked against an edge-count reference model.
module tb_rst_set_gen;
  localparam int S = 2, RH = 8, SH = 4;
  logic clk = 1'b0, rst = 1'b0, ext_rst_n = 1'b1, soft_rst_req = 1'b0, soft_set_req = 1'b0;
  logic rst_o_n, set_o, ready;
  logic [1:0] state;
  int total = 0, bad = 0;
  int e = 0, release_e = 0, until_e = 0, kind = 0;
  bit in_rst = 1'b1;
  rst_set_gen dut (
    .clk(clk),
    .rst(rst),
    .ext_rst_n(ext_rst_n),
    .soft_rst_req(soft_rst_req),
    .soft_set_req(soft_set_req),
    .rst_o_n(rst_o_n),
    .set_o(set_o),
    .state(state),
    .ready(ready)
  );
  always #5 clk = ~clk;
  // Model phases are timed by absolute edge numbers rather than a running counter.
  task automatic model_edge(input bit rr, input bit sr);
    e++;
    if (in_rst) return;
    case (kind)
      0: if (e - release_e == S + RH) kind = 1;
      1: if (rr) begin kind = 3; until_e = e + RH; end
         else if (sr) begin kind = 2; until_e = e + SH; end
      2: if (rr) begin kind = 3; until_e = e + RH; end
         else if (e == until_e) kind = 1;
      default: if (e == until_e) kind = 1;
    endcase
  endtask
  task automatic chk(input string tag);
    logic [4:0] obs, exp;
    obs = {rst_o_n, set_o, state, ready};
    exp = {kind == 1 || kind == 2, kind == 2, 2'(kind), kind == 1};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d {rst_o_n,set_o,state,ready} observed=%b expected=%b", tag, e, obs, exp);
    end
    total++;
    assert ((set_o && !rst_o_n) === 1'b0) else begin
      bad++;
      $error("FAIL %s_overlap edge=%0d set_o=%b rst_o_n=%b", tag, e, set_o, rst_o_n);
    end
  endtask
  task automatic cyc(input bit rr, input bit sr, input string tag);
    soft_rst_req = rr;
    soft_set_req = sr;
    @(posedge clk);
    model_edge(rr, sr);
    #1;
    chk(tag);
    soft_rst_req = 1'b0;
    soft_set_req = 1'b0;
  endtask
  // Mid-cycle low pulse on rst (src=0) or ext_rst_n (src=1); checked before any edge.
  task automatic apulse(input bit src, input string tag);
    #2;
    if (src) ext_rst_n = 1'b0;
    else rst = 1'b0;
    in_rst = 1'b1;
    kind = 0;
    #1;
    chk(tag);
    #1;
    rst = 1'b1;
    ext_rst_n = 1'b1;
    in_rst = 1'b0;
    release_e = e;
  endtask
  initial begin
    #1;
    chk("reset_t0");
    repeat (3) cyc(1'b1, 1'b1, "reset_hold");
    #2;
    rst = 1'b1;
    in_rst = 1'b0;
    release_e = e;
    repeat (12) cyc(1'b0, 1'b0, "release");
    cyc(1'b0, 1'b1, "set_start");
    repeat (5) cyc(1'b0, 1'b0, "set_run");
    cyc(1'b1, 1'b1, "both_start");
    repeat (3) cyc(1'b1, 1'b1, "softr_ignore");
    repeat (6) cyc(1'b0, 1'b0, "both_run");
    cyc(1'b0, 1'b1, "abort_set");
    cyc(1'b0, 1'b1, "abort_setp1");
    cyc(1'b1, 1'b0, "abort_rst");
    repeat (9) cyc(1'b0, 1'b0, "abort_run");
    cyc(1'b1, 1'b0, "softr_enter");
    cyc(1'b0, 1'b0, "softr_mid");
    apulse(1'b1, "ext_pulse");
    repeat (12) cyc(1'b0, 1'b1, "ext_release");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) apulse(1'($urandom_range(0, 1)), "rand_async");
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, "random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_set_gen.md
RST_SET_GEN -- requirements
Module: rst_set_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2; number of synchronizer flops on reset release; SHALL be >= 2.
REQ-002 Parameter RST_HOLD, default 8; clk cycles rst_o_n is held low after sync release or a soft reset; SHALL be >= 1.
REQ-003 Parameter SET_HOLD, default 4; clk cycles set_o is held high per set request; SHALL be >= 1.
REQ-004 clk  input  1  clock; rising edge active.
REQ-005 rst  input  1  block reset; asynchronous, active-low.
REQ-006 ext_rst_n  input  1  external asynchronous reset source; active-low.
REQ-007 soft_rst_req  input  1  synchronous soft-reset request; sampled on a rising clk edge.
REQ-008 soft_set_req  input  1  synchronous set request; sampled on a rising clk edge.
REQ-009 rst_o_n  output  1  generated reset for downstream flop banks; active-low; asserts asynchronously and deasserts synchronously.
REQ-010 set_o  output  1  generated set pulse for downstream flop banks; active-high; registered.
REQ-011 state  output  2  current FSM state encoding.
REQ-012 ready  output  1  high only when state is IDLE and rst_o_n is high.

Function
REQ-013 FSM states SHALL be HOLD=0, IDLE=1, SETP=2, SOFTR=3.
REQ-014 rst low or ext_rst_n low SHALL force rst_o_n=0, set_o=0 and state=HOLD immediately, without waiting for clk, and SHALL clear the synchronizer chain and the hold counter.
REQ-015 After both rst and ext_rst_n are high, the chain SHALL shift in 1s for SYNC_STAGES edges; the counter SHALL then count RST_HOLD edges, with rst_o_n still low.
REQ-016 rst_o_n SHALL rise, and state SHALL enter IDLE, on the (SYNC_STAGES+RST_HOLD)-th rising edge after the later of the two reset deassertions (10th edge with defaults).
REQ-017 In IDLE, soft_rst_req=1 at edge N SHALL drive rst_o_n=0 and state=SOFTR after edge N; rst_o_n SHALL return high and state SHALL return to IDLE after edge N+RST_HOLD.
REQ-018 In IDLE, soft_set_req=1 at edge N SHALL drive set_o=1 and state=SETP after edge N; set_o SHALL fall and state SHALL return to IDLE after edge N+SET_HOLD.
REQ-019 If soft_rst_req and soft_set_req are both high at the same edge, reset SHALL win and the set request SHALL be discarded.
REQ-020 soft_rst_req=1 in SETP SHALL abort the set: set_o SHALL go to 0 and the REQ-017 timing SHALL start at that edge.
REQ-021 soft_set_req in HOLD, SOFTR or SETP SHALL be ignored, not queued.
REQ-022 soft_rst_req in HOLD or SOFTR SHALL be ignored; SOFTR SHALL NOT restart its count.
REQ-023 set_o and rst_o_n=0 SHALL never be active in the same cycle.
REQ-024 A single hold counter SHALL be shared across states, with width clog2(max(RST_HOLD,SET_HOLD)+1); it SHALL saturate rather than wrap.

Reset
REQ-025 Under rst=0: rst_o_n=0, set_o=0, state=HOLD (2'd0), ready=0, synchronizer chain all 0, counter=0.
REQ-026 Reasserting rst or ext_rst_n mid-operation, in any state, SHALL apply REQ-014 and restart the full REQ-016 release sequence.

Structure
REQ-027 A shared package rst_set_pkg SHALL hold the state encoding typedef and the default values of SYNC_STAGES, RST_HOLD and SET_HOLD.
REQ-028 One sub-module, rst_sync, SHALL implement the async-assert/sync-deassert chain (SYNC_STAGES flops, async clear from rst AND ext_rst_n); the FSM, counter and output registers SHALL stay in rst_set_gen.

Verification
REQ-029 Release rst at time t, with ext_rst_n=1, defaults -> rst_o_n low through edge 9 after t, high after edge 10; ready=1 from the same cycle.
REQ-030 In IDLE, pulse soft_set_req for 1 cycle at edge N -> set_o=1 for exactly 4 cycles (edges N..N+4), state sequence 1,2,2,2,2,1.
REQ-031 soft_rst_req and soft_set_req both high at edge N -> rst_o_n=0 for 8 cycles, set_o stays 0 throughout.
REQ-032 soft_rst_req at SETP cycle 2 -> set_o=0 and rst_o_n=0 after that edge; IDLE 8 edges later; set_o and rst_o_n=0 never overlap.
REQ-033 Pulse ext_rst_n low between clock edges while in SOFTR -> rst_o_n=0 and state=0 with no clk edge; full 10-edge release follows.
